// File: rtl/if_fetch_stage_pkg.sv
// -----------------------------------------------------------------------------
// if_fetch_stage_pkg
//   Shared constants and types for the instruction fetch stage.
//   NOP_INST         : instruction placed in IF/ID when it holds no real fetch
//   RESET_PC_DEFAULT : default first fetch address after reset
//   ifid_action_e    : what the IF/ID register does on the next clock edge
//   word_align()     : clears the byte-offset bits of a redirect target
// -----------------------------------------------------------------------------
package if_fetch_stage_pkg;

    localparam logic [31:0] NOP_INST         = 32'h0000_0013;
    localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;

    typedef enum logic [1:0] {
        IFID_FLUSH,
        IFID_HOLD,
        IFID_LOAD,
        IFID_BUBBLE
    } ifid_action_e;

    function automatic logic [31:0] word_align(input logic [31:0] addr);
        return {addr[31:2], 2'b00};
    endfunction

endpackage

// File: rtl/if_fetch_stage_if.sv
// -----------------------------------------------------------------------------
// if_fetch_stage_if
//   Bundles the fetch stage's memory handshake, pipeline control inputs and
//   IF/ID register outputs.
//   master : the fetch stage (drives requests and IF/ID)
//   slave  : the environment (memory, decode, execute)
//   imem_req_*  : request handshake, address sampled only on valid & ready
//   imem_rsp_*  : in-order responses, one per accepted request
//   id_stall, ex_take_branch, ex_target_pc : pipeline control
//   if_id_*     : IF/ID pipeline register contents
// -----------------------------------------------------------------------------
interface if_fetch_stage_if;

    logic        imem_req_valid;
    logic        imem_req_ready;
    logic [31:0] imem_req_addr;
    logic        imem_rsp_valid;
    logic [31:0] imem_rsp_data;
    logic        id_stall;
    logic        ex_take_branch;
    logic [31:0] ex_target_pc;
    logic [31:0] if_id_IR;
    logic [31:0] if_id_PC;
    logic [31:0] if_id_NPC;
    logic        if_id_valid_inst;

    modport master (
        output imem_req_valid, imem_req_addr,
        output if_id_IR, if_id_PC, if_id_NPC, if_id_valid_inst,
        input  imem_req_ready, imem_rsp_valid, imem_rsp_data,
        input  id_stall, ex_take_branch, ex_target_pc
    );

    modport slave (
        input  imem_req_valid, imem_req_addr,
        input  if_id_IR, if_id_PC, if_id_NPC, if_id_valid_inst,
        output imem_req_ready, imem_rsp_valid, imem_rsp_data,
        output id_stall, ex_take_branch, ex_target_pc
    );

endinterface

// File: rtl/if_fetch_stage_fetch_fifo.sv
// -----------------------------------------------------------------------------
// if_fetch_stage_fetch_fifo
//   Synchronous FIFO holding returned instructions until decode takes them.
//   clk, rst       : clock, synchronous active-low reset
//   push/push_data : write an entry
//   pop            : drop the head entry
//   flush          : empty the FIFO; wins over a same-cycle push
//   head_data      : current head entry (meaningless while empty)
//   count/empty/full : occupancy
// -----------------------------------------------------------------------------
module if_fetch_stage_fetch_fifo #(
    parameter  int unsigned DEPTH = 2,
    parameter  int unsigned WIDTH = 32,
    localparam int unsigned CNT_W = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    input  logic             flush,
    output logic [WIDTH-1:0] head_data,
    output logic [CNT_W-1:0] count,
    output logic             empty,
    output logic             full
);

    localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W-1:0] wr_ptr;

    function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    always_ff @(posedge clk) begin
        if (!rst || flush) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= next_ptr(wr_ptr);
            if (pop)  rd_ptr <= next_ptr(rd_ptr);
            case ({push, pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst && !flush && push) mem[wr_ptr] <= push_data;
    end

    assign head_data = mem[rd_ptr];
    assign empty     = (count == '0);
    assign full      = (count == CNT_W'(DEPTH));

endmodule

// File: rtl/if_fetch_stage.sv
// -----------------------------------------------------------------------------
// if_fetch_stage
//   Instruction fetch: issues in-order word fetches, tolerates variable memory
//   latency, buffers responses and drives the IF/ID pipeline register.
//   clk : system clock
//   rst : synchronous, active-low reset
//   bus : if_fetch_stage_if.master (imem request/response, id_stall,
//         ex_take_branch/ex_target_pc, if_id_IR/PC/NPC/valid_inst)
//   RESET_PC : first fetch address after reset
//   DEPTH    : outstanding requests plus buffered responses (power of 2, >=1)
// -----------------------------------------------------------------------------
module if_fetch_stage
    import if_fetch_stage_pkg::*;
#(
    parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT,
    parameter int unsigned DEPTH    = 2
) (
    input logic                clk,
    input logic                rst,
    if_fetch_stage_if.master   bus
);

    localparam int unsigned CNT_W = $clog2(DEPTH + 1);

    logic [31:0]      fetch_pc;
    logic [31:0]      deliver_pc;
    logic [CNT_W-1:0] inflight;
    logic [CNT_W-1:0] inflight_next;
    logic [CNT_W-1:0] drop_cnt;
    logic [CNT_W-1:0] fifo_count;
    logic [CNT_W:0]   credit_used;
    logic [31:0]      fifo_head;
    logic [31:0]      load_inst;
    logic             fifo_empty;
    logic             fifo_full;
    logic             fifo_push;
    logic             fifo_pop;
    logic             accept;
    logic             rsp_keep;
    ifid_action_e     action;

    // Every accepted request owns a FIFO slot until its instruction is
    // consumed, so a stalled decode can never overflow the buffer.
    assign credit_used        = {1'b0, inflight} + {1'b0, fifo_count};
    assign bus.imem_req_valid = (credit_used < (CNT_W + 1)'(DEPTH));
    assign bus.imem_req_addr  = fetch_pc;

    assign accept   = bus.imem_req_valid & bus.imem_req_ready;
    assign rsp_keep = bus.imem_rsp_valid & (drop_cnt == '0);

    always_comb begin
        inflight_next = inflight;
        case ({accept, bus.imem_rsp_valid})
            2'b10:   inflight_next = inflight + CNT_W'(1);
            2'b01:   inflight_next = inflight - CNT_W'(1);
            default: inflight_next = inflight;
        endcase
    end

    always_comb begin
        if (bus.ex_take_branch)              action = IFID_FLUSH;
        else if (bus.id_stall)               action = IFID_HOLD;
        else if (!fifo_empty || rsp_keep)    action = IFID_LOAD;
        else                                 action = IFID_BUBBLE;
    end

    // An empty FIFO lets a kept response go straight into IF/ID.
    assign load_inst = fifo_empty ? bus.imem_rsp_data : fifo_head;
    assign fifo_pop  = (action == IFID_LOAD) && !fifo_empty;
    assign fifo_push = rsp_keep && !fifo_full
                       && !((action == IFID_LOAD) && fifo_empty);

    if_fetch_stage_fetch_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (32)
    ) u_fetch_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (fifo_push),
        .push_data (bus.imem_rsp_data),
        .pop       (fifo_pop),
        .flush     (bus.ex_take_branch),
        .head_data (fifo_head),
        .count     (fifo_count),
        .empty     (fifo_empty),
        .full      (fifo_full)
    );

    always_ff @(posedge clk) begin
        if (!rst) begin
            bus.if_id_IR         <= NOP_INST;
            bus.if_id_PC         <= '0;
            bus.if_id_NPC        <= 32'd4;
            bus.if_id_valid_inst <= 1'b0;
            fetch_pc             <= RESET_PC;
            deliver_pc           <= RESET_PC;
            inflight             <= '0;
            drop_cnt             <= '0;
        end else begin
            inflight <= inflight_next;
            if (action == IFID_FLUSH) begin
                // Everything still outstanding after this edge, including a
                // request accepted right now, belongs to the wrong path.
                drop_cnt             <= inflight_next;
                fetch_pc             <= word_align(bus.ex_target_pc);
                deliver_pc           <= word_align(bus.ex_target_pc);
                bus.if_id_IR         <= NOP_INST;
                bus.if_id_valid_inst <= 1'b0;
            end else begin
                if (accept) fetch_pc <= fetch_pc + 32'd4;
                if (bus.imem_rsp_valid && (drop_cnt != '0))
                    drop_cnt <= drop_cnt - CNT_W'(1);
                case (action)
                    IFID_LOAD: begin
                        bus.if_id_IR         <= load_inst;
                        bus.if_id_PC         <= deliver_pc;
                        bus.if_id_NPC        <= deliver_pc + 32'd4;
                        bus.if_id_valid_inst <= 1'b1;
                        deliver_pc           <= deliver_pc + 32'd4;
                    end
                    IFID_BUBBLE: begin
                        bus.if_id_IR         <= NOP_INST;
                        bus.if_id_valid_inst <= 1'b0;
                    end
                    default: ;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_if_fetch_stage.sv
module tb_if_fetch_stage;
    import if_fetch_stage_pkg::*;

    localparam int unsigned DEPTH = 2;
    localparam logic [31:0] RPC   = 32'h0000_0000;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    if_fetch_stage_if bus ();

    if_fetch_stage #(
        .RESET_PC (RPC),
        .DEPTH    (DEPTH)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int vectors     = 0;
    int miscompares = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] memfn(input logic [31:0] a);
        return 32'h11 + (a >> 2);
    endfunction

    // ---------------- memory model ----------------
    typedef struct {
        logic [31:0] addr;
        int          due;
    } mreq_t;
    mreq_t mq[$];
    int lat      = 1;
    int cyc      = 0;
    int last_due = -1;

    // ---------------- behavioural model ----------------
    // Requests carry the epoch in which they were accepted; a redirect starts
    // a new epoch, so any response tagged with an old epoch is wrong-path.
    logic [31:0] m_fetch, m_deliver;
    int          m_epoch = 0;
    int          outq[$];
    logic [31:0] ibuf_q[$];
    logic [31:0] exp_IR, exp_PC, exp_NPC;
    logic        exp_valid, exp_req_valid;
    logic [31:0] exp_req_addr;
    bit          chk_en = 0;

    task automatic model_update();
        bit m_acc;
        bit fresh;
        int tag;
        if (!rst) begin
            outq.delete();
            ibuf_q.delete();
            m_epoch++;
            m_fetch   = RPC;
            m_deliver = RPC;
            exp_IR    = 32'h0000_0013;
            exp_PC    = 32'h0;
            exp_NPC   = 32'h4;
            exp_valid = 1'b0;
        end else begin
            m_acc = exp_req_valid && bus.imem_req_ready;
            fresh = 0;
            if (bus.imem_rsp_valid && outq.size() > 0) begin
                tag   = outq.pop_front();
                fresh = (tag == m_epoch) && !bus.ex_take_branch;
            end
            if (m_acc) outq.push_back(m_epoch);
            if (bus.ex_take_branch) begin
                m_epoch++;
                ibuf_q.delete();
                m_fetch   = bus.ex_target_pc & 32'hFFFF_FFFC;
                m_deliver = m_fetch;
                exp_IR    = 32'h0000_0013;
                exp_valid = 1'b0;
            end else begin
                if (m_acc) m_fetch = m_fetch + 32'd4;
                if (fresh) ibuf_q.push_back(bus.imem_rsp_data);
                if (!bus.id_stall) begin
                    if (ibuf_q.size() > 0) begin
                        exp_IR    = ibuf_q.pop_front();
                        exp_PC    = m_deliver;
                        exp_NPC   = m_deliver + 32'd4;
                        exp_valid = 1'b1;
                        m_deliver = m_deliver + 32'd4;
                    end else begin
                        exp_IR    = 32'h0000_0013;
                        exp_valid = 1'b0;
                    end
                end
            end
        end
        exp_req_valid = (outq.size() + ibuf_q.size()) < DEPTH;
        exp_req_addr  = m_fetch;
        chk_en        = 1;
    endtask

    // ---------------- compare process ----------------
    always @(posedge clk) begin
        #1;
        if (chk_en) begin
            chk("if_id_valid_inst", 32'(bus.if_id_valid_inst), 32'(exp_valid));
            chk("if_id_IR",         bus.if_id_IR,              exp_IR);
            chk("if_id_PC",         bus.if_id_PC,              exp_PC);
            chk("if_id_NPC",        bus.if_id_NPC,             exp_NPC);
            chk("imem_req_valid",   32'(bus.imem_req_valid),   32'(exp_req_valid));
            chk("imem_req_addr",    bus.imem_req_addr,         exp_req_addr);
        end
    end

    // One clock cycle: memory drives its response, model and memory observe
    // the pre-edge state at the falling edge, then the edge happens.
    task automatic step();
        mreq_t r;
        int    d;
        if (!rst) begin
            mq.delete();
            bus.imem_rsp_valid = 1'b0;
            bus.imem_rsp_data  = 32'hDEAD_BEEF;
        end else if (mq.size() > 0 && mq[0].due <= cyc) begin
            r = mq.pop_front();
            bus.imem_rsp_valid = 1'b1;
            bus.imem_rsp_data  = memfn(r.addr);
        end else begin
            bus.imem_rsp_valid = 1'b0;
            bus.imem_rsp_data  = 32'hDEAD_BEEF;
        end
        @(negedge clk);
        model_update();
        if (rst && bus.imem_req_valid && bus.imem_req_ready) begin
            d = cyc + lat;
            if (d <= last_due) d = last_due + 1;
            last_due = d;
            mq.push_back('{addr: bus.imem_req_addr, due: d});
        end
        cyc++;
        @(posedge clk);
        #2;
    endtask

    task automatic do_reset();
        rst                = 1'b0;
        bus.id_stall       = 1'b0;
        bus.ex_take_branch = 1'b0;
        step();
        rst = 1'b1;
    endtask

    task automatic redirect_test(input logic [31:0] target);
        bit found;
        do_reset();
        lat = 3;
        bus.imem_req_ready = 1'b1;
        step();
        step();
        chk("redir_credits_full", 32'(bus.imem_req_valid), 32'd0);
        bus.ex_take_branch = 1'b1;
        bus.ex_target_pc   = target;
        step();
        bus.ex_take_branch = 1'b0;
        chk("redir_flush_valid", 32'(bus.if_id_valid_inst), 32'd0);
        chk("redir_req_addr",    bus.imem_req_addr,         32'h0000_0100);
        found = 0;
        for (int i = 0; i < 20 && !found; i++) begin
            step();
            if (bus.if_id_valid_inst === 1'b1) begin
                found = 1;
                chk("redir_first_PC",  bus.if_id_PC,  32'h0000_0100);
                chk("redir_first_IR",  bus.if_id_IR,  32'h0000_0051);
                chk("redir_first_NPC", bus.if_id_NPC, 32'h0000_0104);
            end
        end
        if (!found) chk("redir_wait_timeout", 32'd0, 32'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, vectors=%0d", vectors);
        $fatal(1, "watchdog");
    end

    initial begin
        rst                = 1'b0;
        bus.imem_req_ready = 1'b0;
        bus.imem_rsp_valid = 1'b0;
        bus.imem_rsp_data  = 32'h0;
        bus.id_stall       = 1'b0;
        bus.ex_take_branch = 1'b0;
        bus.ex_target_pc   = 32'h0;
        @(posedge clk);
        #2;

        // Reset held for three cycles
        for (int i = 0; i < 3; i++) begin
            step();
            chk("reset_valid", 32'(bus.if_id_valid_inst), 32'd0);
            chk("reset_IR",    bus.if_id_IR,              32'h0000_0013);
        end
        rst = 1'b1;
        bus.imem_req_ready = 1'b1;
        lat = 1;
        chk("first_req_valid", 32'(bus.imem_req_valid), 32'd1);
        chk("first_req_addr",  bus.imem_req_addr,       RPC);

        // Straight line, zero-wait memory: one instruction per cycle
        step();
        for (int i = 0; i < 5; i++) begin
            step();
            chk("line_valid", 32'(bus.if_id_valid_inst), 32'd1);
            chk("line_PC",    bus.if_id_PC,              32'(4 * i));
            chk("line_NPC",   bus.if_id_NPC,             32'(4 * i + 4));
            chk("line_IR",    bus.if_id_IR,              32'(32'h11 + i));
        end

        // Decode stall while PC 8 is showing
        do_reset();
        lat = 1;
        step();
        step();
        step();
        step();
        chk("stall_pre_PC", bus.if_id_PC, 32'h8);
        bus.id_stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            chk("stall_hold_PC",    bus.if_id_PC,              32'h8);
            chk("stall_hold_valid", 32'(bus.if_id_valid_inst), 32'd1);
            if (i == 0) chk("stall_req_drop", 32'(bus.imem_req_valid), 32'd0);
        end
        bus.id_stall = 1'b0;
        step();
        chk("stall_after_PC0", bus.if_id_PC, 32'hC);
        chk("stall_after_IR0", bus.if_id_IR, 32'h14);
        step();
        chk("stall_after_PC1", bus.if_id_PC, 32'h10);
        chk("stall_after_IR1", bus.if_id_IR, 32'h15);

        // Redirect with two stale requests outstanding
        redirect_test(32'h0000_0102);
        redirect_test(32'h0000_0100);

        // Redirect colliding with stall, response arrival and request accept
        do_reset();
        lat = 1;
        bus.imem_req_ready = 1'b1;
        step();
        step();
        step();
        step();
        chk("coll_pre_PC", bus.if_id_PC, 32'h8);
        bus.id_stall       = 1'b1;
        bus.ex_take_branch = 1'b1;
        bus.ex_target_pc   = 32'h0000_0200;
        step();
        bus.id_stall       = 1'b0;
        bus.ex_take_branch = 1'b0;
        chk("coll_flush_valid", 32'(bus.if_id_valid_inst), 32'd0);
        chk("coll_flush_IR",    bus.if_id_IR,              32'h0000_0013);
        chk("coll_req_addr",    bus.imem_req_addr,         32'h0000_0200);
        step();
        chk("coll_stale_dropped", 32'(bus.if_id_valid_inst), 32'd0);
        step();
        chk("coll_new_valid", 32'(bus.if_id_valid_inst), 32'd1);
        chk("coll_new_PC",    bus.if_id_PC,              32'h0000_0200);
        chk("coll_new_IR",    bus.if_id_IR,              32'h0000_0091);

        // Back-pressure, then reset with one request in flight
        do_reset();
        lat = 3;
        bus.imem_req_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            step();
            chk("bp_req_valid", 32'(bus.imem_req_valid), 32'd1);
            chk("bp_req_addr",  bus.imem_req_addr,       32'h0);
        end
        bus.imem_req_ready = 1'b1;
        step();
        chk("bp_accepted_addr", bus.imem_req_addr, 32'h4);
        bus.imem_req_ready = 1'b0;
        rst = 1'b0;
        step();
        rst = 1'b1;
        bus.imem_req_ready = 1'b1;
        chk("rst_restart_addr", bus.imem_req_addr, RPC);
        for (int i = 0; i < 3; i++) begin
            step();
            chk("rst_restart_bubble", 32'(bus.if_id_valid_inst), 32'd0);
        end
        step();
        chk("rst_restart_valid", 32'(bus.if_id_valid_inst), 32'd1);
        chk("rst_restart_PC",    bus.if_id_PC,              32'h0);
        chk("rst_restart_IR",    bus.if_id_IR,              32'h11);
        step();
        step();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
